// File: rtl/sysregs_prot_if.sv
// NORA slave-bus bundle for the system-register block at CPU $9F50.
// The master drives address, write data, strobes and select.
// The slave returns combinational read data.
interface sysregs_prot_if #(
    parameter int unsigned ADDR_W = 5
) ();
    logic [ADDR_W-1:0] slv_addr_i;
    logic [7:0]        slv_datawr_i;
    logic              slv_datawr_valid;
    logic              slv_req_i;
    logic              slv_rwn_i;
    logic [7:0]        slv_datard_o;

    modport master (
        output slv_addr_i, slv_datawr_i, slv_datawr_valid, slv_req_i, slv_rwn_i,
        input  slv_datard_o
    );

    modport slave (
        input  slv_addr_i, slv_datawr_i, slv_datawr_valid, slv_req_i, slv_rwn_i,
        output slv_datard_o
    );
endinterface

// File: rtl/sysregs_prot.sv
// sysregs_prot: the NORA system-register block.
// It provides generic R/W control registers, an UNLOCK key register and a STATUS register.
// It also provides pass-through peripheral windows.
// Selected registers are write-protected behind an A5/5A unlock sequence.
// The unlock times out after UNLOCK_TMO cycles.
// Optional feature macro: SYSREGS_IRQ_EN. It adds the STATUS.ien bit and a registered irq_o.
module sysregs_prot #(
    parameter int unsigned        ADDR_W     = 5,
    parameter int unsigned        NREGS      = 4,
    parameter logic [8*NREGS-1:0] REG_RST    = '0,
    parameter logic [NREGS-1:0]   PROT_MASK  = '0,
    parameter int unsigned        NPER       = 3,
    parameter int unsigned        PER_BASE   = 5,
    parameter int unsigned        UNLOCK_TMO = 255
) (
    input  logic                 clk,
    input  logic                 resetn,
    sysregs_prot_if.slave        slv,
    output logic [8*NREGS-1:0]   regs_o,
    input  logic [8*NPER-1:0]    per_d_i,
    output logic [7:0]           per_d_o,
    output logic [NPER-1:0]      per_cs_o,
    output logic                 per_wr_o,
    output logic                 per_rd_o,
    output logic                 locked_o,
    output logic                 irq_o
);
    typedef enum logic [1:0] {ST_LOCKED, ST_KEY1, ST_UNLOCKED} state_t;

    localparam logic [ADDR_W-1:0] UNLOCK_OFS = ADDR_W'(NREGS);
    localparam logic [ADDR_W-1:0] STATUS_OFS = ADDR_W'(NREGS + 1);
    localparam logic [7:0]        KEY_A      = 8'hA5;
    localparam logic [7:0]        KEY_B      = 8'h5A;
    localparam logic [15:0]       TMO_LOAD   = 16'(UNLOCK_TMO);

    state_t              state_q, state_d;
    logic [15:0]         timer_q, timer_d;
    logic [8*NREGS-1:0]  regs_q, regs_d;
    logic                viol_q, viol_d;
    logic                ien;

    logic                commit;
    logic                wr_unlock;
    logic                wr_status;
    logic                prot_wr;
    logic [NREGS-1:0]    reg_hit;
    logic [NPER-1:0]     per_hit;
    logic                st_key1;
    logic                st_unlocked;
    logic [7:0]          status;
    logic [7:0]          rd_data;

    assign commit    = slv.slv_req_i & ~slv.slv_rwn_i & slv.slv_datawr_valid;
    assign wr_unlock = commit & (slv.slv_addr_i == UNLOCK_OFS);
    assign wr_status = commit & (slv.slv_addr_i == STATUS_OFS);
    assign prot_wr   = commit & |(reg_hit & PROT_MASK);

    // Address decode for the generic registers and the peripheral windows.
    always_comb begin
        reg_hit = '0;
        per_hit = '0;
        for (int unsigned i = 0; i < NREGS; i++)
            reg_hit[i] = (slv.slv_addr_i == ADDR_W'(i));
        for (int unsigned i = 0; i < NPER; i++)
            per_hit[i] = (slv.slv_addr_i == ADDR_W'(PER_BASE + i));
    end

    // State register for the unlock FSM and its lifetime timer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_LOCKED;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic: UNLOCK key writes override timeout.
    // A protected write consumes the unlock.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (state_q == ST_UNLOCKED) begin
            if (timer_q == 16'd1) begin
                state_d = ST_LOCKED;
                timer_d = '0;
            end else begin
                timer_d = timer_q - 16'd1;
            end
        end
        if (wr_unlock) begin
            if (slv.slv_datawr_i == KEY_A) begin
                state_d = ST_KEY1;
                timer_d = '0;
            end else if (state_q == ST_KEY1 && slv.slv_datawr_i == KEY_B) begin
                state_d = ST_UNLOCKED;
                timer_d = TMO_LOAD;
            end else begin
                state_d = ST_LOCKED;
                timer_d = '0;
            end
        end else if (prot_wr && state_q == ST_UNLOCKED) begin
            state_d = ST_LOCKED;
            timer_d = '0;
        end
    end

    // FSM-derived outputs and status bits.
    always_comb begin
        locked_o    = (state_q != ST_UNLOCKED);
        st_key1     = (state_q == ST_KEY1);
        st_unlocked = (state_q == ST_UNLOCKED);
    end

    // Register file and violation flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            regs_q <= REG_RST;
            viol_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            viol_q <= viol_d;
        end
    end

    // Register writes.
    // While locked, a protected write is dropped and sets the violation flag.
    always_comb begin
        regs_d = regs_q;
        viol_d = viol_q;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (commit && reg_hit[i]) begin
                if (!PROT_MASK[i] || state_q == ST_UNLOCKED)
                    regs_d[8*i +: 8] = slv.slv_datawr_i;
                else
                    viol_d = 1'b1;
            end
        end
        if (wr_status && slv.slv_datawr_i[2])
            viol_d = 1'b0;
    end

`ifdef SYSREGS_IRQ_EN
    logic ien_q, ien_d;
    logic irq_q, irq_d;

    // Interrupt enable and registered interrupt output.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ien_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ien_q <= ien_d;
            irq_q <= irq_d;
        end
    end

    // ien follows STATUS bit7 writes.
    // irq follows viol & ien one cycle later.
    always_comb begin
        ien_d = ien_q;
        if (wr_status)
            ien_d = slv.slv_datawr_i[7];
        irq_d = viol_q & ien_q;
    end

    assign ien   = ien_q;
    assign irq_o = irq_q;
`else
    assign ien   = 1'b0;
    assign irq_o = 1'b0;
`endif

    // Read mux and peripheral pass-through.
    always_comb begin
        status  = {ien, 4'b0000, viol_q, st_key1, st_unlocked};
        rd_data = '0;
        for (int unsigned i = 0; i < NREGS; i++)
            if (reg_hit[i]) rd_data = regs_q[8*i +: 8];
        if (slv.slv_addr_i == STATUS_OFS)
            rd_data = status;
        for (int unsigned i = 0; i < NPER; i++)
            if (per_hit[i]) rd_data = per_d_i[8*i +: 8];
        per_cs_o = per_hit & {NPER{slv.slv_req_i}};
        per_wr_o = |per_cs_o & ~slv.slv_rwn_i & slv.slv_datawr_valid;
        per_rd_o = |per_cs_o & slv.slv_rwn_i & slv.slv_datawr_valid;
    end

    assign slv.slv_datard_o = rd_data;
    assign per_d_o          = slv.slv_datawr_i;
    assign regs_o           = regs_q;
endmodule

// File: tb/tb_sysregs_prot.sv
// Self-checking bench for sysregs_prot.
// Configuration: NREGS=3 with reg0 protected, UNLOCK_TMO=4, peripherals at offsets 5..7.
module tb_sysregs_prot;
    localparam int unsigned ADDR_W = 5;
    localparam logic [4:0] UNLK = 5'd3;
    localparam logic [4:0] STAT = 5'd4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [23:0] regs_o;
    logic [23:0] per_d_i = 24'h887766;
    logic [7:0]  per_d_o;
    logic [2:0]  per_cs_o;
    logic        per_wr_o, per_rd_o, locked_o, irq_o;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got, exp;

    sysregs_prot_if #(.ADDR_W(ADDR_W)) bus ();

    sysregs_prot #(
        .ADDR_W(ADDR_W), .NREGS(3), .REG_RST(24'h332211), .PROT_MASK(3'b001),
        .NPER(3), .PER_BASE(5), .UNLOCK_TMO(4)
    ) dut (
        .clk(clk), .resetn(resetn), .slv(bus.slave), .regs_o(regs_o),
        .per_d_i(per_d_i), .per_d_o(per_d_o), .per_cs_o(per_cs_o),
        .per_wr_o(per_wr_o), .per_rd_o(per_rd_o), .locked_o(locked_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    // Callers enter these tasks at posedge+1.
    // Each bus task ends at the next posedge+1.
    task automatic bus_idle_drive();
        bus.slv_req_i = 1'b0; bus.slv_rwn_i = 1'b1; bus.slv_datawr_valid = 1'b0;
        bus.slv_addr_i = '0; bus.slv_datawr_i = '0;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
        bus.slv_addr_i = a; bus.slv_datawr_i = d; bus.slv_req_i = 1'b1;
        bus.slv_rwn_i = 1'b0; bus.slv_datawr_valid = 1'b1;
        @(posedge clk); #1;
        bus_idle_drive();
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [7:0] d);
        bus.slv_addr_i = a; bus.slv_req_i = 1'b1; bus.slv_rwn_i = 1'b1;
        bus.slv_datawr_valid = 1'b1;
        #1 d = bus.slv_datard_o;
        @(posedge clk); #1;
        bus_idle_drive();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_idle_drive();
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;
        n_total++; if (regs_o !== 24'h332211) $display("FAIL reset_regs: got %h expected %h", regs_o, 24'h332211); else n_pass++;
        n_total++; if (locked_o !== 1'b1) $display("FAIL reset_locked: got %b expected 1", locked_o); else n_pass++;
        n_total++; if (irq_o !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq_o); else n_pass++;
        exp_q.push_back(8'h00); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL reset_status: got %h expected %h", got, exp); else n_pass++;
    endtask

    task automatic test_protect_locked();
        bus_write(5'd0, 8'h3C);
        n_total++; if (regs_o[7:0] !== 8'h11) $display("FAIL prot_locked_reg0: got %h expected 11", regs_o[7:0]); else n_pass++;
        exp_q.push_back(8'h04); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL prot_viol_set: got %h expected %h", got, exp); else n_pass++;
        bus_write(STAT, 8'h04);
        exp_q.push_back(8'h00); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL viol_w1c: got %h expected %h", got, exp); else n_pass++;
    endtask

    task automatic test_unlock_oneshot();
        bus_write(UNLK, 8'hA5);
        exp_q.push_back(8'h02); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL key1_status: got %h expected %h", got, exp); else n_pass++;
        bus_write(UNLK, 8'h5A);
        n_total++; if (locked_o !== 1'b0) $display("FAIL unlocked_flag: got %b expected 0", locked_o); else n_pass++;
        exp_q.push_back(8'h01); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL unlocked_status: got %h expected %h", got, exp); else n_pass++;
        bus_write(5'd0, 8'h3C);
        n_total++; if (regs_o[7:0] !== 8'h3C) $display("FAIL oneshot_write: got %h expected 3c", regs_o[7:0]); else n_pass++;
        n_total++; if (locked_o !== 1'b1) $display("FAIL oneshot_relock: got %b expected 1", locked_o); else n_pass++;
        bus_write(5'd0, 8'h77);
        exp_q.push_back(8'h3C); bus_read(5'd0, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL second_write_ignored: got %h expected %h", got, exp); else n_pass++;
        exp_q.push_back(8'h04); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL second_write_viol: got %h expected %h", got, exp); else n_pass++;
        bus_write(STAT, 8'h04);
    endtask

    task automatic test_timeout();
        bus_write(UNLK, 8'hA5);
        bus_write(UNLK, 8'h5A);
        idle(3);
        n_total++; if (locked_o !== 1'b0) $display("FAIL tmo_still_open: got %b expected 0", locked_o); else n_pass++;
        idle(1);
        n_total++; if (locked_o !== 1'b1) $display("FAIL tmo_expired: got %b expected 1", locked_o); else n_pass++;
        bus_write(5'd0, 8'hC3);
        n_total++; if (regs_o[7:0] !== 8'h3C) $display("FAIL tmo_reject: got %h expected 3c", regs_o[7:0]); else n_pass++;
        exp_q.push_back(8'h04); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL tmo_viol: got %h expected %h", got, exp); else n_pass++;
        bus_write(STAT, 8'h04);
        // A write committed in the last unlocked cycle (timer==1) is still accepted.
        bus_write(UNLK, 8'hA5);
        bus_write(UNLK, 8'h5A);
        idle(3);
        bus_write(5'd0, 8'hE1);
        n_total++; if (regs_o[7:0] !== 8'hE1) $display("FAIL tmo_last_cycle_write: got %h expected e1", regs_o[7:0]); else n_pass++;
        exp_q.push_back(8'h00); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL tmo_last_cycle_status: got %h expected %h", got, exp); else n_pass++;
    endtask

    task automatic test_bad_sequence();
        bus_write(UNLK, 8'hA5);
        bus_write(UNLK, 8'h00);
        bus_write(UNLK, 8'h5A);
        exp_q.push_back(8'h00); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL bad_seq_status: got %h expected %h", got, exp); else n_pass++;
        n_total++; if (locked_o !== 1'b1) $display("FAIL bad_seq_locked: got %b expected 1", locked_o); else n_pass++;
        bus_write(UNLK, 8'hA5);
        bus_write(UNLK, 8'hA5);
        bus_write(UNLK, 8'h5A);
        exp_q.push_back(8'h01); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL a5a5_unlock: got %h expected %h", got, exp); else n_pass++;
        bus_write(UNLK, 8'h12);
        exp_q.push_back(8'h00); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL unlocked_restart: got %h expected %h", got, exp); else n_pass++;
        exp_q.push_back(8'h00); bus_read(UNLK, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL unlock_reads_zero: got %h expected %h", got, exp); else n_pass++;
    endtask

    task automatic test_unprotected();
        bus_write(5'd2, 8'hBE);
        exp_q.push_back(8'hBE); bus_read(5'd2, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL unprot_write: got %h expected %h", got, exp); else n_pass++;
        n_total++; if (regs_o[23:16] !== 8'hBE) $display("FAIL unprot_regs_o: got %h expected be", regs_o[23:16]); else n_pass++;
        exp_q.push_back(8'h00); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL unprot_no_viol: got %h expected %h", got, exp); else n_pass++;
        exp_q.push_back(8'h00); bus_read(5'd20, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL unmapped_read: got %h expected %h", got, exp); else n_pass++;
    endtask

    task automatic test_peripheral();
        bus.slv_addr_i = 5'd6; bus.slv_req_i = 1'b1; bus.slv_rwn_i = 1'b1; bus.slv_datawr_valid = 1'b1;
        #1;
        n_total++; if (bus.slv_datard_o !== 8'h77) $display("FAIL per_rd_data: got %h expected 77", bus.slv_datard_o); else n_pass++;
        n_total++; if (per_cs_o !== 3'b010) $display("FAIL per_rd_cs: got %b expected 010", per_cs_o); else n_pass++;
        n_total++; if ({per_rd_o, per_wr_o} !== 2'b10) $display("FAIL per_rd_strobe: got %b expected 10", {per_rd_o, per_wr_o}); else n_pass++;
        bus.slv_datawr_valid = 1'b0;
        #1;
        n_total++; if (per_rd_o !== 1'b0) $display("FAIL per_rd_no_valid: got %b expected 0", per_rd_o); else n_pass++;
        @(posedge clk); #1;
        bus.slv_addr_i = 5'd7; bus.slv_rwn_i = 1'b0; bus.slv_datawr_i = 8'h99; bus.slv_datawr_valid = 1'b1;
        #1;
        n_total++; if ({per_cs_o, per_wr_o, per_rd_o} !== 5'b10010) $display("FAIL per_wr_strobe: got %b expected 10010", {per_cs_o, per_wr_o, per_rd_o}); else n_pass++;
        n_total++; if (per_d_o !== 8'h99) $display("FAIL per_wr_data: got %h expected 99", per_d_o); else n_pass++;
        @(posedge clk); #1;
        bus_idle_drive();
        bus.slv_addr_i = 5'd6;
        #1;
        n_total++; if (per_cs_o !== 3'b000) $display("FAIL per_cs_no_req: got %b expected 000", per_cs_o); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_sequence();
        bus_write(UNLK, 8'hA5);
        bus_write(UNLK, 8'h5A);
        bus_write(5'd1, 8'h55);
        resetn = 1'b0;
        idle(1);
        resetn = 1'b1;
        n_total++; if (regs_o !== 24'h332211) $display("FAIL midreset_regs: got %h expected 332211", regs_o); else n_pass++;
        n_total++; if (locked_o !== 1'b1) $display("FAIL midreset_locked: got %b expected 1", locked_o); else n_pass++;
    endtask

    task automatic test_irq();
`ifdef SYSREGS_IRQ_EN
        bus_write(STAT, 8'h80);
        bus_write(5'd0, 8'h01);
        n_total++; if (irq_o !== 1'b0) $display("FAIL irq_latency: got %b expected 0", irq_o); else n_pass++;
        idle(1);
        n_total++; if (irq_o !== 1'b1) $display("FAIL irq_set: got %b expected 1", irq_o); else n_pass++;
        exp_q.push_back(8'h84); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL irq_status: got %h expected %h", got, exp); else n_pass++;
        bus_write(STAT, 8'h84);
        idle(1);
        n_total++; if (irq_o !== 1'b0) $display("FAIL irq_clear: got %b expected 0", irq_o); else n_pass++;
`else
        bus_write(STAT, 8'h80);
        bus_write(5'd0, 8'h01);
        idle(1);
        n_total++; if (irq_o !== 1'b0) $display("FAIL irq_disabled: got %b expected 0", irq_o); else n_pass++;
        exp_q.push_back(8'h04); bus_read(STAT, got); exp = exp_q.pop_front();
        n_total++; if (got !== exp) $display("FAIL ien_absent: got %h expected %h", got, exp); else n_pass++;
        bus_write(STAT, 8'h04);
`endif
    endtask

    initial begin
        bus_idle_drive();
        @(posedge clk); #1;
        test_reset();
        test_protect_locked();
        test_unlock_oneshot();
        test_timeout();
        test_bad_sequence();
        test_unprotected();
        test_peripheral();
        test_reset_mid_sequence();
        test_irq();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
